// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS pipeline:
//   - default field widths of the data path and of the control word
//   - bit positions inside the WB and MEM control fields
//   - the control word carried by a pipeline bubble
// -----------------------------------------------------------------------------
package mips_pkg;

    // Data path widths
    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int COUNT_W    = 16;

    // Control word widths: WB = {RegWrite, MemtoReg},
    // MEM = {Branch, MemRead, MemWrite}, EX = {RegDst, ALUSrc, Jump, alu_code[3:0]}
    localparam int CTRL_WB_W  = 2;
    localparam int CTRL_MEM_W = 3;
    localparam int CTRL_EX_W  = 7;
    localparam int CTRL_W     = CTRL_WB_W + CTRL_MEM_W + CTRL_EX_W;

    // Bit indices inside the control fields
    localparam int MEM_READ    = 1;
    localparam int MEM_WRITE   = 0;
    localparam int BRANCH      = 2;
    localparam int WB_REGWRITE = 1;

    // A bubble carries no side effects: no RegWrite, MemRead, MemWrite or Branch
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage : mips_pkg

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. A hazard exists when the valid
// instruction in EX is a load whose destination (rt, non-zero) is a source
// register of the instruction currently in ID.
//
// Ports:
//   i_ex_rt        EX-stage rt (load destination)
//   i_ex_mem_read  EX-stage MemRead control bit
//   i_ex_valid     EX-stage entry is a real instruction
//   i_id_rs        ID-stage rs
//   i_id_rt        ID-stage rt
//   o_stall        hazard: stall PC/IF-ID and insert a bubble
// -----------------------------------------------------------------------------
module load_use_detect
    import mips_pkg::*;
#(
    parameter int NB_REG = REG_W
)
(
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    output logic              o_stall
);

    logic w_rt_nonzero;
    logic w_src_match;

    // $0 is hard-wired to zero, so a load into it never creates a dependency
    assign w_rt_nonzero = (i_ex_rt != '0);
    assign w_src_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);

    assign o_stall = i_ex_valid & i_ex_mem_read & w_rt_nonzero & w_src_match;

endmodule : load_use_detect

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with load-use hazard detection, flush and debug
// freeze. Captures the decode-stage control word and operands and presents
// them to EX one cycle later. On a load-use hazard or a taken branch/jump it
// captures a bubble instead; a saturating counter tracks inserted bubbles.
//
// Ports:
//   i_clock, i_reset          clock, asynchronous active-low reset
//   i_halt                    debug freeze, all state holds
//   i_flush                   branch/jump taken, capture a bubble
//   i_ctrl_wb/mem/ex          decode-stage control word
//   i_pc_next                 PC+4 of the decode instruction
//   i_rs_data, i_rt_data      register-file read data
//   i_imm_ext                 sign-extended immediate
//   i_rs, i_rt, i_rd          decode register addresses
//   o_ctrl_wb/mem/ex          registered control word
//   o_pc_next, o_rs_data,
//   o_rt_data, o_imm_ext      registered data
//   o_rs, o_rt, o_rd          registered addresses
//   o_valid                   EX entry is a real instruction
//   o_stall                   combinational, freeze PC and IF/ID this cycle
//   o_bubble_count            saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int NB_DATA     = DATA_W,
    parameter int NB_REG      = REG_W,
    parameter int NB_CTRL_WB  = CTRL_WB_W,
    parameter int NB_CTRL_MEM = CTRL_MEM_W,
    parameter int NB_CTRL_EX  = CTRL_EX_W,
    parameter int NB_COUNT    = COUNT_W
)
(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_halt,
    input  logic                   i_flush,
    input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0] i_ctrl_mem,
    input  logic [NB_CTRL_EX-1:0]  i_ctrl_ex,
    input  logic [NB_DATA-1:0]     i_pc_next,
    input  logic [NB_DATA-1:0]     i_rs_data,
    input  logic [NB_DATA-1:0]     i_rt_data,
    input  logic [NB_DATA-1:0]     i_imm_ext,
    input  logic [NB_REG-1:0]      i_rs,
    input  logic [NB_REG-1:0]      i_rt,
    input  logic [NB_REG-1:0]      i_rd,
    output logic [NB_CTRL_WB-1:0]  o_ctrl_wb,
    output logic [NB_CTRL_MEM-1:0] o_ctrl_mem,
    output logic [NB_CTRL_EX-1:0]  o_ctrl_ex,
    output logic [NB_DATA-1:0]     o_pc_next,
    output logic [NB_DATA-1:0]     o_rs_data,
    output logic [NB_DATA-1:0]     o_rt_data,
    output logic [NB_DATA-1:0]     o_imm_ext,
    output logic [NB_REG-1:0]      o_rs,
    output logic [NB_REG-1:0]      o_rt,
    output logic [NB_REG-1:0]      o_rd,
    output logic                   o_valid,
    output logic                   o_stall,
    output logic [NB_COUNT-1:0]    o_bubble_count
);

    logic [NB_CTRL_WB-1:0]  r_ctrl_wb;
    logic [NB_CTRL_MEM-1:0] r_ctrl_mem;
    logic [NB_CTRL_EX-1:0]  r_ctrl_ex;
    logic [NB_DATA-1:0]     r_pc_next;
    logic [NB_DATA-1:0]     r_rs_data;
    logic [NB_DATA-1:0]     r_rt_data;
    logic [NB_DATA-1:0]     r_imm_ext;
    logic [NB_REG-1:0]      r_rs;
    logic [NB_REG-1:0]      r_rt;
    logic [NB_REG-1:0]      r_rd;
    logic                   r_valid;
    logic [NB_COUNT-1:0]    r_bubble_count;

    logic                   w_stall;
    logic                   w_bubble;
    logic                   w_count_sat;

    // Hazard check works on the registered EX entry, so it stays live while halted
    load_use_detect #(
        .NB_REG (NB_REG)
    ) u_load_use_detect (
        .i_ex_rt       (r_rt),
        .i_ex_mem_read (r_ctrl_mem[MEM_READ]),
        .i_ex_valid    (r_valid),
        .i_id_rs       (i_rs),
        .i_id_rt       (i_rt),
        .o_stall       (w_stall)
    );

    // Flush and stall together still produce a single bubble
    assign w_bubble    = i_flush | w_stall;
    assign w_count_sat = (r_bubble_count == '1);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            {r_ctrl_wb, r_ctrl_mem, r_ctrl_ex} <= CTRL_BUBBLE;
            r_pc_next      <= '0;
            r_rs_data      <= '0;
            r_rt_data      <= '0;
            r_imm_ext      <= '0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_rd           <= '0;
            r_valid        <= 1'b0;
            r_bubble_count <= '0;
        end else if (!i_halt) begin
            if (w_bubble) begin
                {r_ctrl_wb, r_ctrl_mem, r_ctrl_ex} <= CTRL_BUBBLE;
                r_pc_next <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_imm_ext <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_valid   <= 1'b0;
                if (!w_count_sat) begin
                    r_bubble_count <= r_bubble_count + {{(NB_COUNT-1){1'b0}}, 1'b1};
                end
            end else begin
                r_ctrl_wb  <= i_ctrl_wb;
                r_ctrl_mem <= i_ctrl_mem;
                r_ctrl_ex  <= i_ctrl_ex;
                r_pc_next  <= i_pc_next;
                r_rs_data  <= i_rs_data;
                r_rt_data  <= i_rt_data;
                r_imm_ext  <= i_imm_ext;
                r_rs       <= i_rs;
                r_rt       <= i_rt;
                r_rd       <= i_rd;
                r_valid    <= 1'b1;
            end
        end
    end

    assign o_ctrl_wb      = r_ctrl_wb;
    assign o_ctrl_mem     = r_ctrl_mem;
    assign o_ctrl_ex      = r_ctrl_ex;
    assign o_pc_next      = r_pc_next;
    assign o_rs_data      = r_rs_data;
    assign o_rt_data      = r_rt_data;
    assign o_imm_ext      = r_imm_ext;
    assign o_rs           = r_rs;
    assign o_rt           = r_rt;
    assign o_rd           = r_rd;
    assign o_valid        = r_valid;
    assign o_stall        = w_stall;
    assign o_bubble_count = r_bubble_count;

endmodule : id_ex_reg

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Self-checking bench for id_ex_reg: directed scenarios followed by random
// traffic, compared against a transaction-level reference of the EX entry.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        flush;
    logic [1:0]  ctrl_wb;
    logic [2:0]  ctrl_mem;
    logic [6:0]  ctrl_ex;
    logic [31:0] pc_next, rs_data, rt_data, imm_ext;
    logic [4:0]  rs, rt, rd;

    logic [1:0]  o_ctrl_wb;
    logic [2:0]  o_ctrl_mem;
    logic [6:0]  o_ctrl_ex;
    logic [31:0] o_pc_next, o_rs_data, o_rt_data, o_imm_ext;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_valid;
    logic        o_stall;
    logic [15:0] o_bubble_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference EX entry: one record, replaced whole on every capture
    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [6:0]  ex;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } entry_t;

    entry_t      m_ent;
    int unsigned m_bubbles;
    logic [15:0] hold_cnt;
    entry_t      hold_ent;

    id_ex_reg dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_halt         (halt),
        .i_flush        (flush),
        .i_ctrl_wb      (ctrl_wb),
        .i_ctrl_mem     (ctrl_mem),
        .i_ctrl_ex      (ctrl_ex),
        .i_pc_next      (pc_next),
        .i_rs_data      (rs_data),
        .i_rt_data      (rt_data),
        .i_imm_ext      (imm_ext),
        .i_rs           (rs),
        .i_rt           (rt),
        .i_rd           (rd),
        .o_ctrl_wb      (o_ctrl_wb),
        .o_ctrl_mem     (o_ctrl_mem),
        .o_ctrl_ex      (o_ctrl_ex),
        .o_pc_next      (o_pc_next),
        .o_rs_data      (o_rs_data),
        .o_rt_data      (o_rt_data),
        .o_imm_ext      (o_imm_ext),
        .o_rs           (o_rs),
        .o_rt           (o_rt),
        .o_rd           (o_rd),
        .o_valid        (o_valid),
        .o_stall        (o_stall),
        .o_bubble_count (o_bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load-use rule: a valid load in EX writing a non-zero rt read by ID
    function automatic logic model_stall();
        return m_ent.valid && m_ent.mem[1] && (m_ent.rt != 5'd0)
               && (m_ent.rt == rs || m_ent.rt == rt);
    endfunction

    task automatic model_reset();
        m_ent     = '0;
        m_bubbles = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb"},    64'(o_ctrl_wb),      64'(m_ent.wb));
        chk({tag, ".mem"},   64'(o_ctrl_mem),     64'(m_ent.mem));
        chk({tag, ".ex"},    64'(o_ctrl_ex),      64'(m_ent.ex));
        chk({tag, ".pc"},    64'(o_pc_next),      64'(m_ent.pc));
        chk({tag, ".rsd"},   64'(o_rs_data),      64'(m_ent.rsd));
        chk({tag, ".rtd"},   64'(o_rt_data),      64'(m_ent.rtd));
        chk({tag, ".imm"},   64'(o_imm_ext),      64'(m_ent.imm));
        chk({tag, ".rs"},    64'(o_rs),           64'(m_ent.rs));
        chk({tag, ".rt"},    64'(o_rt),           64'(m_ent.rt));
        chk({tag, ".rd"},    64'(o_rd),           64'(m_ent.rd));
        chk({tag, ".valid"}, 64'(o_valid),        64'(m_ent.valid));
        chk({tag, ".cnt"},   64'(o_bubble_count), 64'(m_bubbles));
        chk({tag, ".stall"}, 64'(o_stall),        64'(model_stall()));
    endtask

    // One rising edge; the reference decides the capture from the inputs at the edge
    task automatic do_edge();
        logic bub;
        bub = flush || model_stall();
        @(posedge clk);
        if (rst_n && !halt) begin
            if (bub) begin
                m_ent = '0;
                if (m_bubbles < 65535) m_bubbles++;
            end else begin
                m_ent = '{valid: 1'b1, wb: ctrl_wb, mem: ctrl_mem, ex: ctrl_ex,
                          pc: pc_next, rsd: rs_data, rtd: rt_data, imm: imm_ext,
                          rs: rs, rt: rt, rd: rd};
            end
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        do_edge();
        check_all(tag);
    endtask

    task automatic set_instr(input logic [1:0] wb, input logic [2:0] mem,
                             input logic [6:0] ex, input logic [4:0] a_rs,
                             input logic [4:0] a_rt, input logic [4:0] a_rd);
        ctrl_wb  = wb;
        ctrl_mem = mem;
        ctrl_ex  = ex;
        rs       = a_rs;
        rt       = a_rt;
        rd       = a_rd;
        pc_next  = $urandom;
        rs_data  = $urandom;
        rt_data  = $urandom;
        imm_ext  = $urandom;
    endtask

    task automatic rand_inputs();
        set_instr(2'($urandom), 3'($urandom), 7'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)));
    endtask

    initial begin
        rst_n = 1'b0;
        halt  = 1'b0;
        flush = 1'b0;
        set_instr(2'b00, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0);
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        chk("reset.stall0", 64'(o_stall), 64'd0);

        // First edge after release performs a normal capture
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd3, 5'd4, 5'd5);
        cycle("rtype");
        chk("rtype.valid1", 64'(o_valid), 64'd1);
        chk("rtype.stall0", 64'(o_stall), 64'd0);

        // Load-use: lw rt=8, then add reading $8
        set_instr(2'b11, 3'b010, 7'b0100000, 5'd1, 5'd8, 5'd0);
        cycle("lw");
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd8, 5'd9, 5'd10);
        #1;
        chk("lu.stall1", 64'(o_stall), 64'd1);
        cycle("lu.bubble");
        chk("lu.bubble.valid0", 64'(o_valid), 64'd0);
        chk("lu.bubble.mem0", 64'(o_ctrl_mem), 64'd0);
        chk("lu.stall_fell", 64'(o_stall), 64'd0);
        cycle("lu.add");
        chk("lu.add.rs8", 64'(o_rs), 64'd8);
        chk("lu.cnt1", 64'(o_bubble_count), 64'd1);

        // $0 destination and a store are not hazards
        set_instr(2'b11, 3'b010, 7'b0100000, 5'd1, 5'd0, 5'd0);
        cycle("lw0");
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd0, 5'd2, 5'd3);
        #1;
        chk("lw0.stall0", 64'(o_stall), 64'd0);
        set_instr(2'b00, 3'b001, 7'b0100000, 5'd1, 5'd8, 5'd0);
        cycle("sw");
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd8, 5'd2, 5'd3);
        #1;
        chk("sw.stall0", 64'(o_stall), 64'd0);
        cycle("sw.next");

        // Flush coincident with a stall: one bubble, counter +1
        set_instr(2'b11, 3'b010, 7'b0100000, 5'd1, 5'd8, 5'd0);
        cycle("lw2");
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd7, 5'd8, 5'd3);
        flush = 1'b1;
        #1;
        chk("fs.stall1", 64'(o_stall), 64'd1);
        cycle("fs.bubble");
        chk("fs.cnt2", 64'(o_bubble_count), 64'd2);
        flush = 1'b0;
        cycle("fs.after");
        chk("fs.cnt_still2", 64'(o_bubble_count), 64'd2);
        chk("fs.valid1", 64'(o_valid), 64'd1);

        // Halt: capture a load, freeze for 3 cycles with changing inputs
        set_instr(2'b11, 3'b010, 7'b0100000, 5'd1, 5'd8, 5'd0);
        cycle("lw3");
        hold_ent = m_ent;
        hold_cnt = o_bubble_count;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            rs = 5'd8;
            flush = 1'($urandom);
            cycle("halt");
            chk("halt.valid_held", 64'(o_valid), 64'(hold_ent.valid));
            chk("halt.pc_held", 64'(o_pc_next), 64'(hold_ent.pc));
            chk("halt.cnt_held", 64'(o_bubble_count), 64'(hold_cnt));
            chk("halt.stall_live", 64'(o_stall), 64'd1);
        end
        halt  = 1'b0;
        flush = 1'b0;
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd2, 5'd3, 5'd4);
        cycle("unhalt");
        chk("unhalt.rs2", 64'(o_rs), 64'd2);

        // Random traffic with occasional flush, halt and async reset
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            flush = ($urandom_range(0, 7) == 0);
            halt  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rnd.rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle("rnd");
        end
        halt  = 1'b0;
        flush = 1'b0;

        // Saturation: keep flushing well past 2^16-1 bubbles
        flush = 1'b1;
        for (int i = 0; i < 65540; i++) do_edge();
        check_all("sat");
        chk("sat.ffff", 64'(o_bubble_count), 64'hFFFF);
        cycle("sat.hold");
        chk("sat.nowrap", 64'(o_bubble_count), 64'hFFFF);
        flush = 1'b0;

        // Async reset asserted mid-stall, between clock edges
        set_instr(2'b11, 3'b010, 7'b0100000, 5'd1, 5'd8, 5'd0);
        cycle("lw4");
        set_instr(2'b10, 3'b000, 7'b1000010, 5'd8, 5'd9, 5'd3);
        #1;
        chk("rst.pre_stall1", 64'(o_stall), 64'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst.async");
        chk("rst.cnt0", 64'(o_bubble_count), 64'd0);
        chk("rst.valid0", 64'(o_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rst.recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_reg
